// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC operand types, gain constant and default latency
package cordic_pkg;
  localparam int CORDIC_DW = 10;
  typedef logic signed [CORDIC_DW-1:0] dw_t;
  typedef logic signed [CORDIC_DW-1:0] aw_t;
  // 1/K gain compensation in Q1.9 (0.60725)
  localparam dw_t CORDIC_LAMBDA = 10'sd311;
  function automatic int lat(input int iter);
    return iter + 1;
  endfunction
endpackage

// File: rtl/cordic_rr_arb.sv
// cordic_rr_arb: N-way round-robin grant; CORDIC_ARB_FIXED_PRIO_EN selects fixed priority (lowest index)
module cordic_rr_arb #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] ptr;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (adv && any) ptr <= IW'((int'(idx) + 1) % N);
`endif
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++)
      if (!any && valid[IW'((int'(ptr) + k) % N)]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one pipelined CORDIC rotator among NREQ requesters with ID-tagged responses (CORDIC_ARB_FIXED_PRIO_EN: fixed priority)
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = 10,
  parameter int AW = DW,
  parameter int LAT = lat(DW),
  parameter int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  input  logic [NREQ*AW-1:0] req_a,
  output logic               cor_en,
  output logic [DW-1:0]      cor_xin,
  output logic [DW-1:0]      cor_yin,
  output logic [AW-1:0]      cor_ain,
  input  logic [DW-1:0]      cor_xout,
  input  logic [DW-1:0]      cor_yout,
  input  logic [AW-1:0]      cor_arem,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_x,
  output logic [DW-1:0]      rsp_y,
  output logic [AW-1:0]      rsp_a
);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  idx;
  logic            any;
  logic [LAT-1:0]  tv;
  logic [IDW-1:0]  tid [LAT];
  assign cor_en    = !rsp_valid || rsp_ready;
  assign req_ready = gnt & {NREQ{cor_en}};
  cordic_rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
    .clk, .rst, .adv(cor_en), .valid(req_valid), .gnt, .idx, .any
  );
  assign cor_xin = any ? req_x[int'(idx)*DW +: DW] : '0;
  assign cor_yin = any ? req_y[int'(idx)*DW +: DW] : '0;
  assign cor_ain = any ? req_a[int'(idx)*AW +: AW] : '0;
  // tags move in lockstep with the rotator stages, bubbles included
  always_ff @(posedge clk)
    if (rst) tv <= '0;
    else if (cor_en) tv <= {tv[LAT-2:0], any};
  always_ff @(posedge clk)
    if (cor_en) begin
      tid[0] <= idx;
      for (int i = 1; i < LAT; i++) tid[i] <= tid[i-1];
    end
  assign rsp_valid = tv[LAT-1];
  assign rsp_id    = tid[LAT-1];
  assign rsp_x     = cor_xout;
  assign rsp_y     = cor_yout;
  assign rsp_a     = cor_arem;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed stimulus with a queue scoreboard and behavioural rotator model
module tb_cordic_arbiter;
  localparam int N = 4, DW = 10, AW = 10, LAT = 11, IDW = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_x = '0, req_y = '0;
  logic [N*AW-1:0] req_a = '0;
  logic cor_en, rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] cor_xin, cor_yin, cor_xout, cor_yout, rsp_x, rsp_y;
  logic [AW-1:0] cor_ain, cor_arem, rsp_a;
  logic [IDW-1:0] rsp_id;

  cordic_arbiter #(.NREQ(N), .DW(DW), .AW(AW), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_a(req_a), .cor_en(cor_en),
    .cor_xin(cor_xin), .cor_yin(cor_yin), .cor_ain(cor_ain),
    .cor_xout(cor_xout), .cor_yout(cor_yout), .cor_arem(cor_arem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_a(rsp_a)
  );

  // ideal gain-compensated rotator, LAT en-gated stages, residual angle 0
  logic [DW-1:0] sx [LAT], sy [LAT];
  logic [AW-1:0] sa [LAT];
  function automatic logic [DW-1:0] rot(logic [DW-1:0] x, logic [DW-1:0] y, logic [AW-1:0] a, bit yo);
    real th = $itor($signed(a)) * 3.14159265358979 / 512.0;
    real xr = $itor($signed(x));
    real yr = $itor($signed(y));
    real v = yo ? xr * $sin(th) + yr * $cos(th) : xr * $cos(th) - yr * $sin(th);
    int r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    return r[DW-1:0];
  endfunction
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin sx[i] <= '0; sy[i] <= '0; sa[i] <= '0; end
    end else if (cor_en) begin
      sx[0] <= rot(cor_xin, cor_yin, cor_ain, 1'b0);
      sy[0] <= rot(cor_xin, cor_yin, cor_ain, 1'b1);
      sa[0] <= '0;
      for (int i = 1; i < LAT; i++) begin sx[i] <= sx[i-1]; sy[i] <= sy[i-1]; sa[i] <= sa[i-1]; end
    end
  assign cor_xout = sx[LAT-1];
  assign cor_yout = sy[LAT-1];
  assign cor_arem = sa[LAT-1];

  int ecnt = 0;
  always @(posedge clk) if (cor_en) ecnt <= ecnt + 1;

  typedef struct {int id; int x; int y; int a; int tol; int e;} exp_t;
  exp_t q [$];
  int cmp = 0, bad = 0;

  task automatic chk(string n, longint act, longint req, int tol);
    cmp++;
    if (act - req > tol || req - act > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, req, $time);
    end
  endtask

  // monitor: pops on every response handshake and checks held data under stall
  logic held = 1'b0;
  logic [31:0] hv;
  exp_t e;
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) chk("hold", {rsp_id, rsp_x, rsp_y, rsp_a}, hv, 0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          cmp++; bad++;
          $display("FAIL bubble: rsp_valid with id %0d, none expected", rsp_id);
        end else begin
          e = q.pop_front();
          chk("rsp_id", rsp_id, e.id, 0);
          chk("rsp_x", $signed(rsp_x), e.x, e.tol);
          chk("rsp_y", $signed(rsp_y), e.y, e.tol);
          chk("rsp_a", $signed(rsp_a), e.a, e.tol);
          chk("latency", ecnt, e.e + LAT, 0);
        end
      end
      held = rsp_valid && !rsp_ready;
      hv = {rsp_id, rsp_x, rsp_y, rsp_a};
    end
  end

  int cnt [N];
  logic [DW-1:0] opx [N], opy [N], ex [N], ey [N];
  logic [AW-1:0] opa [N];
  int tl [N];

  task automatic set_op(int i);
    opx[i] = DW'(64 * i + 8 * cnt[i] + 1);
    opy[i] = DW'(-(64 * i + 8 * cnt[i] + 1));
    opa[i] = '0;
    ex[i] = opx[i];
    ey[i] = opy[i];
    tl[i] = 0;
  endtask

  // one cycle: g is the requester expected to be accepted, -1 for none
  task automatic cyc(logic [N-1:0] v, int g, logic rr);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_x[i*DW +: DW] = opx[i];
      req_y[i*DW +: DW] = opy[i];
      req_a[i*AW +: AW] = opa[i];
    end
    @(negedge clk);
    chk("req_ready", req_ready, g >= 0 ? (1 << g) : 0, 0);
    if (g >= 0) begin
      q.push_back('{id: g, x: $signed(ex[g]), y: $signed(ey[g]), a: 0, tol: tl[g], e: ecnt});
      cnt[g]++;
      set_op(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) begin cnt[i] = 0; set_op(i); end
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0, 0);
    chk("rst_req_ready", req_ready, 0, 0);
    chk("rst_cor_en", cor_en, 1, 0);
    chk("rst_cor_xin", cor_xin, 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) cyc('0, -1, 1'b1);
    chk("drain_left", q.size(), 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single rotation by pi/2 from requester 2
    do_reset();
    opx[2] = 10'sd256; opy[2] = '0; opa[2] = 10'sd256;
    ex[2] = '0; ey[2] = 10'sd256; tl[2] = 2;
    cyc(4'b0100, 2, 1'b1);
    repeat (LAT + 2) cyc('0, -1, 1'b1);
    chk("single_done", q.size(), 0, 0);
    // all requesters streaming
    do_reset();
    for (int c = 0; c < 12; c++) cyc(4'hf, c % 4, 1'b1);
    drain();
    // back-pressure while a request waits
    do_reset();
    cyc(4'b0010, 1, 1'b1);
    repeat (9) cyc('0, -1, 1'b1);
    cyc(4'b0010, 1, 1'b1);
    repeat (3) cyc(4'b0010, -1, 1'b0);
    repeat (3) cyc(4'b0010, 1, 1'b1);
    drain();
    // sparse traffic
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1000, 3, 1'b1);
      repeat (2) cyc('0, -1, 1'b1);
    end
    cyc(4'b0001, 0, 1'b1);
    drain();
    // reset with six operations in flight
    do_reset();
    for (int c = 0; c < 6; c++) cyc(4'hf, c % 4, 1'b1);
    repeat (2) cyc('0, -1, 1'b1);
    do_reset();
    repeat (LAT + 2) cyc('0, -1, 1'b1);
    cyc(4'b0100, 2, 1'b1);
    drain();
    // requesters 1 and 3 always valid
    do_reset();
    for (int c = 0; c < 6; c++)
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      cyc(4'b1010, 1, 1'b1);
`else
      cyc(4'b1010, (c % 2) ? 3 : 1, 1'b1);
`endif
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
